// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: gray-coded FSM states,
// default widths, the legal oversampling ratios and the 2-of-3 vote.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_START  = 3'b001,
      ST_DATA   = 3'b011,
      ST_PARITY = 3'b010,
      ST_STOP   = 3'b110
   } rx_state_e;

   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_PRESCALE_WIDTH = 6;

   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and mid-bit 3-sample majority vote.
// The vote is registered, so it is usable from ec = P/2+2 onwards.
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      i_clr,
   input  logic [PRESCALE_WIDTH-1:0] i_prescale,
   input  logic                      i_rx,
   output logic [PRESCALE_WIDTH-1:0] o_ec,
   output logic                      o_bit_tick,
   output logic                      o_sampled_bit
);

   logic [PRESCALE_WIDTH-1:0] r_ec;
   logic                      r_s0;
   logic                      r_s1;
   logic                      r_maj;
   logic [PRESCALE_WIDTH-1:0] w_half;
   logic                      w_tick;

   assign w_half = i_prescale >> 1;
   assign w_tick = (r_ec == i_prescale - PRESCALE_WIDTH'(1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_ec  <= '0;
         r_s0  <= 1'b1;
         r_s1  <= 1'b1;
         r_maj <= 1'b1;
      end else begin
         if (i_clr || w_tick) r_ec <= '0;
         else                 r_ec <= r_ec + PRESCALE_WIDTH'(1);
         if (r_ec == w_half - PRESCALE_WIDTH'(1)) r_s0 <= i_rx;
         if (r_ec == w_half)                      r_s1 <= i_rx;
         // Third sample is voted straight from the line, saving a flop.
         if (r_ec == w_half + PRESCALE_WIDTH'(1)) r_maj <= maj3(r_s0, r_s1, i_rx);
      end
   end

   assign o_ec          = r_ec;
   assign o_bit_tick    = w_tick;
   assign o_sampled_bit = r_maj;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: synchronizes RX_IN, walks start/data/parity/stop and
// hands each error-free byte downstream with a one-cycle Data_Valid.
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   output logic [DATA_WIDTH-1:0]     P_DATA,
   output logic                      Data_Valid,
   output logic                      par_err,
   output logic                      stp_err
);

   localparam int BC_WIDTH = $clog2(DATA_WIDTH + 2);

   rx_state_e                 r_state;
   rx_state_e                 w_next_state;
   logic                      r_sync1;
   logic                      r_sync2;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic                      r_par_en;
   logic                      r_par_typ;
   logic [BC_WIDTH-1:0]       r_bc;
   logic [DATA_WIDTH-1:0]     r_shift;
   logic [DATA_WIDTH-1:0]     r_pdata;
   logic                      r_par_mis;
   logic                      r_par_err;
   logic                      r_stp_err;
   logic [PRESCALE_WIDTH-1:0] w_ec;
   logic                      w_bit_tick;
   logic                      w_bit;
   logic                      w_sample_valid;
   logic                      w_start;
   logic                      w_conclude;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= RX_IN;
         r_sync2 <= r_sync1;
      end
   end

   uart_rx_sampler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_sampler (
      .CLK           (CLK),
      .RST           (RST),
      .i_clr         (r_state == ST_IDLE),
      .i_prescale    (r_prescale),
      .i_rx          (r_sync2),
      .o_ec          (w_ec),
      .o_bit_tick    (w_bit_tick),
      .o_sampled_bit (w_bit)
   );

   assign w_sample_valid = (w_ec == (r_prescale >> 1) + PRESCALE_WIDTH'(2));
   assign w_start        = (r_state == ST_IDLE) && !r_sync2;
   assign w_conclude     = (r_state == ST_STOP) && w_sample_valid;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= ST_IDLE;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (!r_sync2) w_next_state = ST_START;
         ST_START: begin
            if (w_sample_valid && w_bit) w_next_state = ST_IDLE;
            else if (w_bit_tick)         w_next_state = ST_DATA;
         end
         ST_DATA:   if (w_bit_tick && r_bc == BC_WIDTH'(DATA_WIDTH))
                       w_next_state = r_par_en ? ST_PARITY : ST_STOP;
         ST_PARITY: if (w_bit_tick) w_next_state = ST_STOP;
         ST_STOP:   if (w_sample_valid) w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // The accepted byte is forwarded during the pulse itself so a
   // downstream register sees it together with Data_Valid.
   always_comb begin
      Data_Valid = 1'b0;
      P_DATA     = r_pdata;
      if (w_conclude && w_bit && !r_par_mis) begin
         Data_Valid = 1'b1;
         P_DATA     = r_shift;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_prescale <= '0;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
         r_bc       <= '0;
         r_shift    <= '0;
         r_pdata    <= '0;
         r_par_mis  <= 1'b0;
         r_par_err  <= 1'b0;
         r_stp_err  <= 1'b0;
      end else begin
         if (w_start) begin
            r_prescale <= Prescale;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_bc       <= '0;
            r_par_mis  <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
         end else if (w_bit_tick) begin
            r_bc <= r_bc + BC_WIDTH'(1);
         end
         if (r_state == ST_DATA && w_sample_valid)
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
         if (r_state == ST_PARITY && w_sample_valid)
            r_par_mis <= w_bit != ((^r_shift) ^ r_par_typ);
         if (w_conclude) begin
            r_par_err <= r_par_mis;
            r_stp_err <= !w_bit;
            if (Data_Valid) r_pdata <= r_shift;
         end
      end
   end

   assign par_err = r_par_err;
   assign stp_err = r_stp_err;

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
UART receiver: the receive-side counterpart of the team's UART TX path (start / data LSB-first / optional parity / stop).
- Oversamples RX_IN at Prescale clocks per bit and majority-votes 3 samples around mid-bit.
- Deserializes DATA_WIDTH bits and checks parity and stop bit.
- Presents the byte with a one-cycle Data_Valid pulse to the downstream (system/register-file) side.

Parameters:
DATA_WIDTH, 8, payload bits per frame.
PRESCALE_WIDTH, 6, width of Prescale input and of the internal edge counter.

Ports:
CLK  in  1  system clock, oversampling rate (Prescale x baud).
RST  in  1  reset, asynchronous, active-low.
RX_IN  in  1  serial line; idle high; asynchronous to CLK.
PAR_EN  in  1  1 = frame carries a parity bit.
PAR_TYP  in  1  0 = even, 1 = odd.
Prescale  in  PRESCALE_WIDTH  clocks per bit; legal values 8, 16, 32.
P_DATA  out  DATA_WIDTH  last correctly received byte.
Data_Valid  out  1  one-cycle pulse; P_DATA is new and error-free.
par_err  out  1  parity error in last frame; held until next frame start.
stp_err  out  1  stop-bit error in last frame; held until next frame start.

Behaviour:
- Reset (RST=0, async): state IDLE; P_DATA=0; Data_Valid=0; par_err=0; stp_err=0; counters and synchronizer flops set to idle (synchronizer to 1).
- RX_IN passes through a 2-flop synchronizer (sync_rx); all logic below uses sync_rx.
- Configuration capture: Prescale, PAR_EN and PAR_TYP are latched on IDLE->START. Mid-frame changes are ignored. Any Prescale outside 8/16/32 gives undefined behaviour.
- Edge counter (ec): 0 in the first START cycle; increments every CLK; wraps Prescale-1 -> 0 at each bit boundary. Bit counter (bc) increments on each wrap.
- Sampling: sync_rx is sampled at ec = P/2-1, P/2 and P/2+1. The 2-of-3 majority is registered and valid from ec = P/2+2.
- States are gray-coded: IDLE, START, DATA, PARITY, STOP.
- IDLE: if sync_rx==0, go to START, clear par_err and stp_err, clear ec and bc.
- START: at ec=P/2+2, if majority==1 treat as a glitch and return to IDLE (no flags, no Data_Valid). Otherwise at ec=P-1 go to DATA.
- DATA: at ec=P/2+2, shift the majority into the shift register LSB-first (bit k goes to position k). At ec=P-1 after bit DATA_WIDTH-1, go to PARITY if PAR_EN, else STOP.
- PARITY: at ec=P/2+2, compare the majority with the expected bit (XOR of data, inverted when PAR_TYP=1). Record the mismatch internally. At ec=P-1 go to STOP.
- STOP: at ec=P/2+2 the frame is concluded in that single cycle:
  - par_err = parity mismatch (always 0 when PAR_EN=0).
  - stp_err = (majority==0).
  - If neither error: P_DATA <= shift register and Data_Valid=1 for exactly that cycle.
  - Next state is IDLE. The rest of the stop bit is spent in IDLE, which tolerates baud skew and back-to-back frames.
- Latency: Data_Valid fires (N-1)*P + P/2+2 cycles after the first START cycle, where N=10 (no parity) or 11 (parity).
  - P=8, no parity: 78 cycles.
  - P=8, parity: 86 cycles.
  - Add 2-3 cycles from the RX_IN falling edge for the synchronizer.
- On an erroneous frame, P_DATA keeps its previous value and Data_Valid stays 0.
- A line held low (break) gives stp_err=1, then IDLE immediately sees 0 and starts a new frame. This is the intended behaviour.
- Reset mid-frame: everything returns to reset values immediately; no Data_Valid for the partial frame.

Decomposition:
- Package uart_rx_pkg holds:
  - state encodings (gray: IDLE 000, START 001, DATA 011, PARITY 010, STOP 110);
  - the DATA_WIDTH default;
  - legal prescale constants 8/16/32.
- One sub-module, uart_rx_sampler: edge counter plus 3-sample majority vote, with outputs ec, bit_tick (wrap) and sampled_bit (valid flag at P/2+2).
- The deserializer, parity check and stop check stay in uart_rx_fsm.

Test Plan:
- P=8, PAR_EN=1, PAR_TYP=0: frame 0xA5, parity bit 0, stop 1 -> Data_Valid pulse of 1 cycle at 86 cycles after START entry; P_DATA=0xA5; par_err=0; stp_err=0.
- P=16, PAR_EN=1, PAR_TYP=1: byte 0x3C sent with parity bit 0 (wrong; odd requires 1) -> par_err=1, Data_Valid never asserted, P_DATA unchanged.
- P=8, PAR_EN=0: byte 0x81 with stop bit driven 0 -> stp_err=1, Data_Valid=0. The next valid frame 0x42 clears stp_err at its start and pulses Data_Valid with P_DATA=0x42.
- Glitch: RX_IN low for 2 clocks only (P=8) -> FSM returns to IDLE at ec=6 of START; no flags, no Data_Valid.
- Back-to-back at P=32, PAR_EN=0: 0x00, 0xFF and 0x55 with no idle gap -> three Data_Valid pulses exactly 10*32=320 cycles apart, in order.
- Reset mid-frame: RST low during DATA bit 3 -> outputs immediately 0. The following full frame 0x7E is received correctly.
